flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Downstream consumer of the ALU flag outputs. Flags use a 3-bit {N,V,Z} vector: [2]=N, [1]=V, [0]=Z, with Z=1 meaning a zero result.
- Holds the architectural flag register and updates only the flag bits each opcode is allowed to modify (for example, XOR touches Z only).
- Resolves conditional-branch requests from decode against the flags, with a registered response and a hazard stall.
- Sits between the EX-stage ALU and the fetch/PC-select logic.

Parameters:
- FLAG_W, 3, width of the flag vector {N,V,Z}
- OPC_W, 4, width of the opcode field
- CCC_W, 3, width of the branch condition code

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a valid instruction this cycle
- ex_opcode  in  OPC_W  opcode of the EX instruction
- ex_flag_in  in  FLAG_W  {N,V,Z} produced by the ALU for the EX instruction
- stall_in  in  1  pipeline freeze; no state changes while high
- flush  in  1  discard any pending branch request
- br_req  in  1  decode presents a conditional branch (B/BR)
- br_ccc  in  CCC_W  branch condition code
- flags_q  out  FLAG_W  committed flag register
- br_stall  out  1  decode must hold the branch this cycle
- br_resp_valid  out  1  branch resolution valid (one-cycle pulse)
- br_taken  out  1  resolution result; qualified by br_resp_valid

Behaviour:
- Reset (async, rst_n=0):
  - flags_q=3'b000; br_resp_valid=0; br_taken=0.
  - FSM=IDLE, so br_stall=0.
  - Reset mid-wait abandons the pending branch; no response is produced.
- Flag write mask, applied at the clock edge when ex_valid=1 and stall_in=0:
  - ADD 0000, SUB 0001: write N,V,Z.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only.
  - All other opcodes: no write.
  - Masked bits keep their prior value.
- Condition evaluation, on flag vector F:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always taken
- Hazard: a flag write is in flight when ex_valid=1 and ex_opcode writes any flag.
- FSM states IDLE, WAIT_FLAGS:
  - IDLE, br_req=1, no hazard: evaluate on flags_q. Next cycle br_resp_valid=1 and br_taken=result. Stay IDLE.
  - IDLE, br_req=1, hazard: br_stall=1 combinationally. Latch br_ccc, go to WAIT_FLAGS.
  - WAIT_FLAGS: br_stall=0. Evaluate the latched ccc on the now-committed flags_q. Next cycle br_resp_valid=1. Return to IDLE.
- Latency: 1 cycle without a hazard, 2 cycles with a hazard.
- stall_in=1 freezes flags_q, the FSM and the latched ccc; br_resp_valid is forced to 0 that cycle.
- flush=1 (takes priority over br_req): FSM goes to IDLE, no response next cycle, flag writes still commit.
- Simultaneous flag write and branch evaluation in IDLE without a hazard: not possible by definition. Back-to-back branches are accepted every cycle.
- br_resp_valid is a single-cycle pulse; br_taken holds its value when br_resp_valid=0.

Optional Feature:
- FLAG_BRANCH_FWD_EN defined:
  - No WAIT_FLAGS path and br_stall is tied 0.
  - On a hazard, evaluation uses the forwarded value: (ex_flag_in AND write mask) OR (flags_q AND NOT write mask).
  - Latency is always 1 cycle.
- Not defined: stall-based behaviour as in Behaviour.

Decomposition:
- Shared package wisc_pkg holds:
  - opcode localparams (OPC_ADD through OPC_HLT)
  - flag index constants FLAG_Z=0, FLAG_V=1, FLAG_N=2
  - CCC_* encodings
  - fsm state typedef.
- One sub-module: branch_cond_eval, purely combinational, mapping (ccc, flags) to taken. It is reused by the hazard and forwarding paths.

Test Plan:
- Reset test: reset, then ADD with ex_flag_in=3'b111 -> flags_q=3'b111 next cycle. Then XOR with ex_flag_in=3'b000 -> flags_q=3'b110 (only Z cleared).
- Masking test: flags_q=3'b010, LW/LLB with ex_flag_in=3'b111 -> flags_q stays 3'b010.
- Condition sweep: with flags_q=3'b001 (Z=1), issue all eight ccc -> taken pattern NE0 EQ1 GT0 LT0 GE1 LE1 OV0 UNC1, each with br_resp_valid one cycle after br_req.
- Hazard test (macro off): SUB producing Z=1 in EX while decode issues br_req with ccc=001 -> br_stall=1 for one cycle, br_resp_valid on cycle+2, br_taken=1.
- Forwarding test (macro on): the same stimulus as the hazard test -> br_stall=0, br_resp_valid on cycle+1, br_taken=1.
- Control events: hazard branch followed by flush during WAIT_FLAGS -> no br_resp_valid. Then stall_in held for 3 cycles during a pending request -> response delayed exactly 3 cycles. Then rst_n asserted mid-WAIT -> all outputs return to 0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, flag bit positions, branch condition codes,
// the branch-resolution FSM state type and the per-opcode flag write mask.
package wisc_pkg;

    localparam int WISC_FLAG_W = 3;
    localparam int WISC_OPC_W  = 4;
    localparam int WISC_CCC_W  = 3;

    localparam logic [WISC_OPC_W-1:0] OPC_ADD    = 4'b0000;
    localparam logic [WISC_OPC_W-1:0] OPC_SUB    = 4'b0001;
    localparam logic [WISC_OPC_W-1:0] OPC_XOR    = 4'b0010;
    localparam logic [WISC_OPC_W-1:0] OPC_RED    = 4'b0011;
    localparam logic [WISC_OPC_W-1:0] OPC_SLL    = 4'b0100;
    localparam logic [WISC_OPC_W-1:0] OPC_SRA    = 4'b0101;
    localparam logic [WISC_OPC_W-1:0] OPC_ROR    = 4'b0110;
    localparam logic [WISC_OPC_W-1:0] OPC_PADDSB = 4'b0111;
    localparam logic [WISC_OPC_W-1:0] OPC_LW     = 4'b1000;
    localparam logic [WISC_OPC_W-1:0] OPC_SW     = 4'b1001;
    localparam logic [WISC_OPC_W-1:0] OPC_LLB    = 4'b1010;
    localparam logic [WISC_OPC_W-1:0] OPC_LHB    = 4'b1011;
    localparam logic [WISC_OPC_W-1:0] OPC_B      = 4'b1100;
    localparam logic [WISC_OPC_W-1:0] OPC_BR     = 4'b1101;
    localparam logic [WISC_OPC_W-1:0] OPC_PCS    = 4'b1110;
    localparam logic [WISC_OPC_W-1:0] OPC_HLT    = 4'b1111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    localparam logic [WISC_FLAG_W-1:0] FLAG_MASK_ALL  = 3'b111;
    localparam logic [WISC_FLAG_W-1:0] FLAG_MASK_Z    = 3'b001;
    localparam logic [WISC_FLAG_W-1:0] FLAG_MASK_NONE = 3'b000;

    localparam logic [WISC_CCC_W-1:0] CCC_NE  = 3'b000;
    localparam logic [WISC_CCC_W-1:0] CCC_EQ  = 3'b001;
    localparam logic [WISC_CCC_W-1:0] CCC_GT  = 3'b010;
    localparam logic [WISC_CCC_W-1:0] CCC_LT  = 3'b011;
    localparam logic [WISC_CCC_W-1:0] CCC_GE  = 3'b100;
    localparam logic [WISC_CCC_W-1:0] CCC_LE  = 3'b101;
    localparam logic [WISC_CCC_W-1:0] CCC_OV  = 3'b110;
    localparam logic [WISC_CCC_W-1:0] CCC_UNC = 3'b111;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_WAIT_FLAGS = 1'b1
    } br_state_t;

    // Which {N,V,Z} bits an opcode is allowed to overwrite.
    function automatic logic [WISC_FLAG_W-1:0] flag_wmask(input logic [WISC_OPC_W-1:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB:                   flag_wmask = FLAG_MASK_ALL;
            OPC_XOR, OPC_SLL, OPC_SRA, OPC_ROR: flag_wmask = FLAG_MASK_Z;
            default:                            flag_wmask = FLAG_MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition check: maps a condition code and an
// {N,V,Z} flag vector to a taken/not-taken decision.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [WISC_CCC_W-1:0]  ccc_i,
    input  logic [WISC_FLAG_W-1:0] flags_i,
    output logic                   taken_o
);

    logic n;
    logic v;
    logic z;

    assign n = flags_i[FLAG_N];
    assign v = flags_i[FLAG_V];
    assign z = flags_i[FLAG_Z];

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        taken_o = 1'b0;
        case (ccc_i)
            CCC_NE:  taken_o = !z;
            CCC_EQ:  taken_o = z;
            CCC_GT:  taken_o = !z && !n;
            CCC_LT:  taken_o = n;
            CCC_GE:  taken_o = z || !n;  // "Z, or not Z and not N" reduces to this
            CCC_LE:  taken_o = n || z;
            CCC_OV:  taken_o = v;
            CCC_UNC: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register with per-opcode write masking, plus conditional
// branch resolution. Define FLAG_BRANCH_FWD_EN to forward EX flags instead of stalling.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int FLAG_W = WISC_FLAG_W,
    parameter int OPC_W  = WISC_OPC_W,
    parameter int CCC_W  = WISC_CCC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [FLAG_W-1:0] ex_flag_in,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              br_req,
    input  logic [CCC_W-1:0]  br_ccc,
    output logic [FLAG_W-1:0] flags_q,
    output logic              br_stall,
    output logic              br_resp_valid,
    output logic              br_taken
);

`ifdef FLAG_BRANCH_FWD_EN
    localparam logic HAZARD_STALL_EN = 1'b0;
`else
    localparam logic HAZARD_STALL_EN = 1'b1;
`endif

    logic [FLAG_W-1:0] wmask;
    logic [FLAG_W-1:0] fwd_flags;
    logic [FLAG_W-1:0] flags_d;
    logic              hazard;

    br_state_t         state_q;
    br_state_t         state_d;
    logic [CCC_W-1:0]  ccc_q;
    logic [CCC_W-1:0]  ccc_d;
    logic              resp_valid_q;
    logic              resp_valid_d;
    logic              taken_q;
    logic              taken_d;

    logic [CCC_W-1:0]  eval_ccc;
    logic [FLAG_W-1:0] eval_flags;
    logic              eval_taken;

    assign wmask     = ex_valid ? flag_wmask(ex_opcode) : FLAG_MASK_NONE;
    assign hazard    = |wmask;
    // Post-write view of the flags; equals flags_q when nothing is being written.
    assign fwd_flags = (ex_flag_in & wmask) | (flags_q & ~wmask);
    assign flags_d   = stall_in ? flags_q : fwd_flags;

    assign eval_ccc   = (state_q == ST_WAIT_FLAGS) ? ccc_q : br_ccc;
    assign eval_flags = HAZARD_STALL_EN ? flags_q : fwd_flags;

    branch_cond_eval u_cond (
        .ccc_i   (eval_ccc),
        .flags_i (eval_flags),
        .taken_o (eval_taken)
    );

    always_comb begin
        state_d      = state_q;
        ccc_d        = ccc_q;
        resp_valid_d = 1'b0;
        taken_d      = taken_q;
        br_stall     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_req && !flush) begin
                    if (HAZARD_STALL_EN && hazard) begin
                        br_stall = 1'b1;
                        if (!stall_in) begin
                            state_d = ST_WAIT_FLAGS;
                            ccc_d   = br_ccc;
                        end
                    end else if (!stall_in) begin
                        resp_valid_d = 1'b1;
                        taken_d      = eval_taken;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (!stall_in) begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        resp_valid_d = 1'b1;
                        taken_d      = eval_taken;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= '0;
            state_q      <= ST_IDLE;
            ccc_q        <= '0;
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            state_q      <= state_d;
            ccc_q        <= ccc_d;
            resp_valid_q <= resp_valid_d;
            taken_q      <= taken_d;
        end
    end

    assign br_resp_valid = resp_valid_q;
    assign br_taken      = taken_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit; expectations follow FLAG_BRANCH_FWD_EN
// when it is defined for the build.
module tb_flag_branch_unit;
    import wisc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [2:0] ex_flag_in;
    logic       stall_in;
    logic       flush;
    logic       br_req;
    logic [2:0] br_ccc;
    logic [2:0] flags_q;
    logic       br_stall;
    logic       br_resp_valid;
    logic       br_taken;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flag_branch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_flag_in    (ex_flag_in),
        .stall_in      (stall_in),
        .flush         (flush),
        .br_req        (br_req),
        .br_ccc        (br_ccc),
        .flags_q       (flags_q),
        .br_stall      (br_stall),
        .br_resp_valid (br_resp_valid),
        .br_taken      (br_taken)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [3:0] opc, input logic [2:0] fl);
        ex_valid   = v;
        ex_opcode  = opc;
        ex_flag_in = fl;
    endtask

    task automatic drive_br(input logic req, input logic [2:0] ccc);
        br_req = req;
        br_ccc = ccc;
    endtask

    task automatic set_flags(input logic [3:0] opc, input logic [2:0] fl, input logic [2:0] exp);
        drive_br(1'b0, 3'b000);
        drive_ex(1'b1, opc, fl);
        tick();
        drive_ex(1'b0, OPC_HLT, 3'b000);
        check("set_flags", 8'(flags_q), 8'(exp));
    endtask

    // exp_taken[i] is the expected outcome for condition code i.
    task automatic sweep(input string name, input logic [7:0] exp_taken);
        for (int i = 0; i < 8; i++) begin
            drive_br(1'b1, 3'(i));
            #1;
            check($sformatf("%s_stall_c%0d", name, i), 8'(br_stall), 8'd0);
            tick();
            check($sformatf("%s_valid_c%0d", name, i), 8'(br_resp_valid), 8'd1);
            check($sformatf("%s_taken_c%0d", name, i), 8'(br_taken), 8'(exp_taken[i]));
        end
        drive_br(1'b0, 3'b000);
        tick();
        check($sformatf("%s_idle_valid", name), 8'(br_resp_valid), 8'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        stall_in = 1'b0;
        flush    = 1'b0;
        drive_ex(1'b0, OPC_HLT, 3'b000);
        drive_br(1'b0, 3'b000);

        // Reset state
        #12;
        check("rst_flags", 8'(flags_q), 8'd0);
        check("rst_valid", 8'(br_resp_valid), 8'd0);
        check("rst_taken", 8'(br_taken), 8'd0);
        check("rst_stall", 8'(br_stall), 8'd0);
        rst_n = 1'b1;

        // Write masking
        set_flags(OPC_ADD, 3'b111, 3'b111);
        set_flags(OPC_XOR, 3'b000, 3'b110);
        set_flags(OPC_SUB, 3'b010, 3'b010);
        set_flags(OPC_LW,  3'b111, 3'b010);
        set_flags(OPC_LLB, 3'b111, 3'b010);
        set_flags(OPC_ROR, 3'b101, 3'b011);

        // Condition sweeps, back-to-back requests
        set_flags(OPC_ADD, 3'b001, 3'b001);
        sweep("z_set", 8'b1011_0010);
        set_flags(OPC_ADD, 3'b100, 3'b100);
        sweep("n_set", 8'b1010_1001);
        set_flags(OPC_SUB, 3'b010, 3'b010);
        sweep("v_set", 8'b1101_0101);

        // Not-taken baseline, then hazard: SUB makes Z=1 while EQ branch arrives
        set_flags(OPC_ADD, 3'b000, 3'b000);
        drive_br(1'b1, CCC_EQ);
        tick();
        check("base_valid", 8'(br_resp_valid), 8'd1);
        check("base_taken", 8'(br_taken), 8'd0);
        drive_ex(1'b1, OPC_SUB, 3'b001);
        drive_br(1'b1, CCC_EQ);
        #1;
`ifdef FLAG_BRANCH_FWD_EN
        check("haz_stall", 8'(br_stall), 8'd0);
        tick();
        drive_ex(1'b0, OPC_HLT, 3'b000);
        drive_br(1'b0, 3'b000);
        check("haz_flags", 8'(flags_q), 8'b001);
        check("haz_valid_c1", 8'(br_resp_valid), 8'd1);
        check("haz_taken", 8'(br_taken), 8'd1);
`else
        check("haz_stall", 8'(br_stall), 8'd1);
        tick();
        drive_ex(1'b0, OPC_HLT, 3'b000);
        drive_br(1'b0, 3'b000);
        #1;
        check("haz_flags", 8'(flags_q), 8'b001);
        check("haz_valid_c1", 8'(br_resp_valid), 8'd0);
        check("haz_stall_wait", 8'(br_stall), 8'd0);
        tick();
        check("haz_valid_c2", 8'(br_resp_valid), 8'd1);
        check("haz_taken", 8'(br_taken), 8'd1);
`endif
        tick();
        check("haz_pulse_end", 8'(br_resp_valid), 8'd0);
        check("haz_taken_hold", 8'(br_taken), 8'd1);

        // Flush beats a branch request, flag write still commits
        drive_ex(1'b1, OPC_ADD, 3'b100);
        drive_br(1'b1, CCC_UNC);
        flush = 1'b1;
        #1;
        check("flush_stall", 8'(br_stall), 8'd0);
        tick();
        flush = 1'b0;
        drive_ex(1'b0, OPC_HLT, 3'b000);
        drive_br(1'b0, 3'b000);
        check("flush_valid", 8'(br_resp_valid), 8'd0);
        check("flush_flags", 8'(flags_q), 8'b100);
        tick();
        check("flush_valid_2", 8'(br_resp_valid), 8'd0);

        // stall_in held 3 cycles on an idle request; flag write frozen too
        drive_br(1'b1, CCC_EQ);
        drive_ex(1'b1, OPC_ADD, 3'b000);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("istall_valid_%0d", i), 8'(br_resp_valid), 8'd0);
            check($sformatf("istall_flags_%0d", i), 8'(flags_q), 8'b100);
        end
        stall_in = 1'b0;
        drive_ex(1'b0, OPC_HLT, 3'b000);
        tick();
        drive_br(1'b0, 3'b000);
        check("istall_valid", 8'(br_resp_valid), 8'd1);
        check("istall_taken", 8'(br_taken), 8'd0);
        tick();

`ifndef FLAG_BRANCH_FWD_EN
        // Flush while waiting for flags: response abandoned
        drive_ex(1'b1, OPC_SUB, 3'b000);
        drive_br(1'b1, CCC_NE);
        tick();
        drive_ex(1'b0, OPC_HLT, 3'b000);
        drive_br(1'b0, 3'b000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("wflush_valid", 8'(br_resp_valid), 8'd0);
        tick();
        check("wflush_valid_2", 8'(br_resp_valid), 8'd0);

        // stall_in held 3 cycles in WAIT_FLAGS delays the response by exactly 3
        drive_ex(1'b1, OPC_SUB, 3'b010);
        drive_br(1'b1, CCC_OV);
        tick();
        drive_br(1'b0, 3'b000);
        drive_ex(1'b1, OPC_ADD, 3'b101);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wstall_valid_%0d", i), 8'(br_resp_valid), 8'd0);
            check($sformatf("wstall_flags_%0d", i), 8'(flags_q), 8'b010);
        end
        stall_in = 1'b0;
        drive_ex(1'b0, OPC_HLT, 3'b000);
        tick();
        check("wstall_valid", 8'(br_resp_valid), 8'd1);
        check("wstall_taken", 8'(br_taken), 8'd1);
        tick();
`endif

        // Async reset while a hazard branch is pending
        drive_ex(1'b1, OPC_SUB, 3'b111);
        drive_br(1'b1, CCC_UNC);
        tick();
        drive_ex(1'b0, OPC_HLT, 3'b000);
        drive_br(1'b0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_flags", 8'(flags_q), 8'd0);
        check("mrst_valid", 8'(br_resp_valid), 8'd0);
        check("mrst_taken", 8'(br_taken), 8'd0);
        check("mrst_stall", 8'(br_stall), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mrst_no_resp", 8'(br_resp_valid), 8'd0);
        tick();
        check("mrst_no_resp_2", 8'(br_resp_valid), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
